pc_sequencer: RTL and testbench
===============================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter RESET_PC, default 30'h0000_0000, word address loaded on reset.
REQ-002 SHALL have parameter ADDR_W, default 30, word-address width; RTL is exercised only at 30.
REQ-003 SHALL have port clk, input, 1, sole clock, rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port stall, input, 1, freezes the PC when high.
REQ-006 SHALL have port fetch_ready, input, 1, instruction memory accepts the presented address.
REQ-007 SHALL have port br_taken, input, 1, conditional branch resolved taken.
REQ-008 SHALL have port br_offset, input, 30, sign-extended 16-bit word offset from the sign-extend stage.
REQ-009 SHALL have port jump, input, 1, J/JAL redirect.
REQ-010 SHALL have port jtarget, input, 26, jump target field.
REQ-011 SHALL have port jr, input, 1, register-indirect redirect.
REQ-012 SHALL have port jr_addr, input, 32, byte address; bits [1:0] ignored.
REQ-013 SHALL have port pc, output, 30, current word address.
REQ-014 SHALL have port pc_byte, output, 32, {pc,2'b00}.
REQ-015 SHALL have port fetch_valid, output, 1, pc is a valid fetch request.
REQ-016 SHALL have port flush, output, 1, one-cycle pulse on redirect, squashing the fetched instruction.

Function
REQ-017 SHALL implement states BOOT, RUN, HOLD.
REQ-018 BOOT SHALL last exactly one cycle after reset release with fetch_valid=0, then go to RUN.
REQ-019 RUN SHALL assert fetch_valid=1 and go to HOLD when stall=1 or fetch_ready=0.
REQ-020 HOLD SHALL assert fetch_valid=1, keep pc unchanged, and return to RUN in the cycle in which stall=0 and fetch_ready=1.
REQ-021 An address SHALL advance only on cycles with fetch_valid=1, fetch_ready=1, stall=0 (accept cycle).
REQ-022 Next-PC priority SHALL be jr > jump > br_taken > sequential.
REQ-023 Sequential next PC SHALL be pc+1; branch next PC SHALL be pc+1+br_offset; jump next PC SHALL be {pc[29:26],jtarget}; jr next PC SHALL be jr_addr[31:2]; all arithmetic is modulo 2^30 and wraps silently.
REQ-024 A redirect asserted on a non-accept cycle SHALL be latched into a pending register (target plus valid bit), with the higher-priority source overwriting any existing pending redirect, and SHALL be applied on the next accept cycle ahead of live inputs of equal or lower priority.
REQ-025 flush SHALL pulse high for one cycle in the cycle after a redirect is applied, and SHALL never assert in BOOT.
REQ-026 pc SHALL update one cycle after the accept cycle (latency 1).
REQ-027 At pc=30'h3FFF_FFFF, a sequential step SHALL produce 30'h0000_0000.

Reset
REQ-028 Asserting reset SHALL immediately force pc=RESET_PC, state=BOOT, fetch_valid=0, flush=0, and pending redirect cleared, including when reset arrives mid-HOLD or mid-pending.

Configuration
REQ-029 With PC_SEQUENCER_REDIRECT_CNT_EN defined, the block SHALL add output redirect_cnt (16 bits), reset to 0, incremented on each flush pulse and saturating at 16'hFFFF; without the macro, the port and counter SHALL be absent.

Structure
REQ-030 Package nextaddr_pkg SHALL hold the state enum, ADDR_W, and the RESET_PC default.
REQ-031 Target selection SHALL live in combinational sub-module nextaddr_mux.

Verification
REQ-032 Reset release with fetch_ready=1 -> one BOOT cycle with fetch_valid=0, then pc=0,1,2,3 on consecutive cycles.
REQ-033 pc=30'h100, br_taken=1, br_offset=30'h3FFF_FFFC (-4) -> pc=30'h0FD, flush pulses once.
REQ-034 jr=1 (jr_addr=32'h0000_4008) and jump=1 in the same accept cycle -> pc=30'h1002.
REQ-035 jump asserted during stall=1 for 3 cycles -> pc held, then pc={pc[29:26],jtarget} on the first accept cycle, flush one cycle later.
REQ-036 pc=30'h3FFF_FFFF sequential -> pc=0; reset mid-HOLD with a pending redirect -> pc=RESET_PC, no flush.
REQ-037 With the macro defined, 70000 redirects -> redirect_cnt=16'hFFFF.

Source files
------------

// File: rtl/nextaddr_pkg.sv
// Shared types and constants for the PC sequencer and its next-address mux.
package nextaddr_pkg;

    localparam int ADDR_W = 30;
    localparam logic [ADDR_W-1:0] RESET_PC_DEFAULT = 30'h0000_0000;

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        HOLD
    } state_e;

    // Ordered so that a numerically larger source wins a priority comparison.
    typedef enum logic [1:0] {
        SRC_NONE,
        SRC_BR,
        SRC_JUMP,
        SRC_JR
    } src_e;

endpackage

// File: rtl/nextaddr_mux.sv
// Combinational next-address selection: live redirect priority (jr > jump > branch > sequential)
// and arbitration between a pending redirect and the live inputs.
module nextaddr_mux
    import nextaddr_pkg::*;
#(
    parameter int W = ADDR_W
) (
    input  logic [W-1:0] pc,
    input  logic         br_taken,
    input  logic [W-1:0] br_offset,
    input  logic         jump,
    input  logic [25:0]  jtarget,
    input  logic         jr,
    input  logic [W-1:0] jr_word,
    input  logic         pend_valid,
    input  src_e         pend_src,
    input  logic [W-1:0] pend_target,
    output src_e         live_src,
    output logic [W-1:0] live_target,
    output logic [W-1:0] next_pc,
    output logic         redirect
);

    logic [W-1:0] seq_pc;

    assign seq_pc = pc + W'(1);

    always_comb begin
        live_src    = SRC_NONE;
        live_target = seq_pc;
        if (jr) begin
            live_src    = SRC_JR;
            live_target = jr_word;
        end else if (jump) begin
            live_src    = SRC_JUMP;
            live_target = {pc[W-1:26], jtarget};
        end else if (br_taken) begin
            live_src    = SRC_BR;
            live_target = seq_pc + br_offset;
        end
    end

    // A pending redirect beats live inputs of equal or lower priority.
    always_comb begin
        next_pc  = live_target;
        redirect = (live_src != SRC_NONE);
        if (pend_valid && (pend_src >= live_src)) begin
            next_pc  = pend_target;
            redirect = 1'b1;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Instruction fetch PC sequencer with BOOT/RUN/HOLD control and a pending-redirect register.
// Optional PC_SEQUENCER_REDIRECT_CNT_EN adds a saturating 16-bit redirect_cnt output.
module pc_sequencer #(
    parameter int                ADDR_W   = nextaddr_pkg::ADDR_W,
    parameter logic [ADDR_W-1:0] RESET_PC = nextaddr_pkg::RESET_PC_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              fetch_ready,
    input  logic              br_taken,
    input  logic [ADDR_W-1:0] br_offset,
    input  logic              jump,
    input  logic [25:0]       jtarget,
    input  logic              jr,
    input  logic [31:0]       jr_addr,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W+1:0] pc_byte,
    output logic              fetch_valid,
    output logic              flush
`ifdef PC_SEQUENCER_REDIRECT_CNT_EN
    ,
    output logic [15:0]       redirect_cnt
`endif
);

    import nextaddr_pkg::*;

    state_e            state;
    state_e            state_next;
    logic              accept;
    logic              pend_valid;
    src_e              pend_src;
    logic [ADDR_W-1:0] pend_target;
    src_e              live_src;
    logic [ADDR_W-1:0] live_target;
    logic [ADDR_W-1:0] next_pc;
    logic              redirect;
    logic              jr_addr_unused;

    assign jr_addr_unused = ^jr_addr[1:0];
    assign accept         = fetch_valid && fetch_ready && !stall;
    assign pc_byte        = {pc, 2'b00};

    nextaddr_mux #(
        .W (ADDR_W)
    ) u_mux (
        .pc          (pc),
        .br_taken    (br_taken),
        .br_offset   (br_offset),
        .jump        (jump),
        .jtarget     (jtarget),
        .jr          (jr),
        .jr_word     (jr_addr[ADDR_W+1:2]),
        .pend_valid  (pend_valid),
        .pend_src    (pend_src),
        .pend_target (pend_target),
        .live_src    (live_src),
        .live_target (live_target),
        .next_pc     (next_pc),
        .redirect    (redirect)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= BOOT;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        fetch_valid = 1'b1;
        case (state)
            BOOT: begin
                fetch_valid = 1'b0;
                state_next  = RUN;
            end
            RUN: begin
                if (stall || !fetch_ready) begin
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (!stall && fetch_ready) begin
                    state_next = RUN;
                end
            end
            default: begin
                fetch_valid = 1'b0;
                state_next  = BOOT;
            end
        endcase
    end

    // Redirects seen while the PC cannot move are parked; a lower-priority one never displaces a higher one.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc          <= RESET_PC;
            flush       <= 1'b0;
            pend_valid  <= 1'b0;
            pend_src    <= SRC_NONE;
            pend_target <= '0;
        end else begin
            flush <= accept && redirect;
            if (accept) begin
                pc         <= next_pc;
                pend_valid <= 1'b0;
                pend_src   <= SRC_NONE;
            end else if ((live_src != SRC_NONE) && (!pend_valid || (live_src >= pend_src))) begin
                pend_valid  <= 1'b1;
                pend_src    <= live_src;
                pend_target <= live_target;
            end
        end
    end

`ifdef PC_SEQUENCER_REDIRECT_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            redirect_cnt <= '0;
        end else if (flush && (redirect_cnt != 16'hFFFF)) begin
            redirect_cnt <= redirect_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed-vector bench for pc_sequencer; define PC_SEQUENCER_REDIRECT_CNT_EN to also cover redirect_cnt.
`timescale 1ns/1ps
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        fetch_ready;
    logic        br_taken;
    logic [29:0] br_offset;
    logic        jump;
    logic [25:0] jtarget;
    logic        jr;
    logic [31:0] jr_addr;
    logic [29:0] pc;
    logic [31:0] pc_byte;
    logic        fetch_valid;
    logic        flush;
`ifdef PC_SEQUENCER_REDIRECT_CNT_EN
    logic [15:0] redirect_cnt;
`endif

    int applied     = 0;
    int miscompares = 0;

    typedef struct {
        logic        stall;
        logic        fetch_ready;
        logic        br_taken;
        logic [29:0] br_offset;
        logic        jump;
        logic [25:0] jtarget;
        logic        jr;
        logic [31:0] jr_addr;
        logic [29:0] exp_pc;
        logic        exp_fv;
        logic        exp_flush;
    } vec_t;

    vec_t table_v[22];

    pc_sequencer dut (
        .clk          (clk),
        .reset        (reset),
        .stall        (stall),
        .fetch_ready  (fetch_ready),
        .br_taken     (br_taken),
        .br_offset    (br_offset),
        .jump         (jump),
        .jtarget      (jtarget),
        .jr           (jr),
        .jr_addr      (jr_addr),
        .pc           (pc),
        .pc_byte      (pc_byte),
        .fetch_valid  (fetch_valid),
        .flush        (flush)
`ifdef PC_SEQUENCER_REDIRECT_CNT_EN
        ,
        .redirect_cnt (redirect_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic st, input logic fr, input logic bt, input logic [29:0] off,
                                input logic jp, input logic [25:0] jt, input logic jrr, input logic [31:0] ja,
                                input logic [29:0] epc, input logic efv, input logic efl);
        vec_t v;
        v.stall       = st;
        v.fetch_ready = fr;
        v.br_taken    = bt;
        v.br_offset   = off;
        v.jump        = jp;
        v.jtarget     = jt;
        v.jr          = jrr;
        v.jr_addr     = ja;
        v.exp_pc      = epc;
        v.exp_fv      = efv;
        v.exp_flush   = efl;
        return v;
    endfunction

    function automatic vec_t idle(input logic [29:0] epc, input logic efl);
        return mk(1'b0, 1'b1, 1'b0, 30'h0, 1'b0, 26'h0, 1'b0, 32'h0, epc, 1'b1, efl);
    endfunction

    // Drive inputs away from the edge, then sample 1ns after the next rising edge.
    task automatic applyStimulus(input vec_t v);
        stall       = v.stall;
        fetch_ready = v.fetch_ready;
        br_taken    = v.br_taken;
        br_offset   = v.br_offset;
        jump        = v.jump;
        jtarget     = v.jtarget;
        jr          = v.jr;
        jr_addr     = v.jr_addr;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [29:0] epc, input logic efv, input logic efl);
        applied++;
        if (pc !== epc || pc_byte !== {epc, 2'b00} || fetch_valid !== efv || flush !== efl) begin
            miscompares++;
            $display("[TB] FAIL %s: got pc=%h pc_byte=%h fetch_valid=%b flush=%b, want pc=%h pc_byte=%h fetch_valid=%b flush=%b",
                     name, pc, pc_byte, fetch_valid, flush, epc, {epc, 2'b00}, efv, efl);
        end
    endtask

    task automatic runVec(input string name, input vec_t v);
        applyStimulus(v);
        checkOutput(name, v.exp_pc, v.exp_fv, v.exp_flush);
    endtask

    initial begin
        table_v[0]  = idle(30'h0, 1'b0);
        table_v[1]  = idle(30'h1, 1'b0);
        table_v[2]  = idle(30'h2, 1'b0);
        table_v[3]  = idle(30'h3, 1'b0);
        table_v[4]  = mk(1'b1, 1'b1, 1'b0, 30'h0, 1'b0, 26'h0, 1'b0, 32'h0, 30'h3, 1'b1, 1'b0);
        table_v[5]  = mk(1'b0, 1'b0, 1'b0, 30'h0, 1'b0, 26'h0, 1'b0, 32'h0, 30'h3, 1'b1, 1'b0);
        table_v[6]  = idle(30'h4, 1'b0);
        table_v[7]  = mk(1'b0, 1'b1, 1'b1, 30'h3FFF_FFFC, 1'b0, 26'h0, 1'b0, 32'h0, 30'h1, 1'b1, 1'b1);
        table_v[8]  = idle(30'h2, 1'b0);
        table_v[9]  = mk(1'b0, 1'b1, 1'b0, 30'h0, 1'b1, 26'hFF, 1'b0, 32'h0, 30'hFF, 1'b1, 1'b1);
        table_v[10] = idle(30'h100, 1'b0);
        table_v[11] = mk(1'b0, 1'b1, 1'b1, 30'h3FFF_FFFC, 1'b0, 26'h0, 1'b0, 32'h0, 30'h0FD, 1'b1, 1'b1);
        table_v[12] = idle(30'h0FE, 1'b0);
        table_v[13] = mk(1'b0, 1'b1, 1'b0, 30'h0, 1'b1, 26'h3, 1'b1, 32'h0000_4008, 30'h1002, 1'b1, 1'b1);
        table_v[14] = mk(1'b0, 1'b1, 1'b1, 30'h5, 1'b1, 26'h2000, 1'b0, 32'h0, 30'h2000, 1'b1, 1'b1);
        table_v[15] = mk(1'b0, 1'b1, 1'b1, 30'h5, 1'b0, 26'h0, 1'b0, 32'h0, 30'h2006, 1'b1, 1'b1);
        table_v[16] = idle(30'h2007, 1'b0);
        table_v[17] = mk(1'b0, 1'b0, 1'b0, 30'h0, 1'b0, 26'h0, 1'b0, 32'h0, 30'h2007, 1'b1, 1'b0);
        table_v[18] = idle(30'h2008, 1'b0);
        table_v[19] = mk(1'b0, 1'b1, 1'b0, 30'h0, 1'b0, 26'h0, 1'b1, 32'hC000_0010, 30'h3000_0004, 1'b1, 1'b1);
        table_v[20] = mk(1'b0, 1'b1, 1'b0, 30'h0, 1'b1, 26'h55, 1'b0, 32'h0, 30'h3000_0055, 1'b1, 1'b1);
        table_v[21] = idle(30'h3000_0056, 1'b0);

        reset       = 1'b1;
        stall       = 1'b0;
        fetch_ready = 1'b1;
        br_taken    = 1'b0;
        br_offset   = '0;
        jump        = 1'b0;
        jtarget     = '0;
        jr          = 1'b0;
        jr_addr     = '0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("in_reset", 30'h0, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        checkOutput("boot", 30'h0, 1'b0, 1'b0);

        for (int i = 0; i < 22; i++) begin
            runVec($sformatf("vec%0d", i), table_v[i]);
        end

        // Jump parked across a 3-cycle stall; a lower-priority branch must neither displace nor beat it.
        runVec("pend_jump_s1", mk(1'b1, 1'b1, 1'b0, 30'h0, 1'b1, 26'h1234, 1'b0, 32'h0, 30'h3000_0056, 1'b1, 1'b0));
        runVec("pend_jump_s2", mk(1'b1, 1'b1, 1'b1, 30'h7, 1'b0, 26'h0, 1'b0, 32'h0, 30'h3000_0056, 1'b1, 1'b0));
        runVec("pend_jump_s3", mk(1'b1, 1'b1, 1'b0, 30'h0, 1'b0, 26'h0, 1'b0, 32'h0, 30'h3000_0056, 1'b1, 1'b0));
        runVec("pend_jump_apply", mk(1'b0, 1'b1, 1'b1, 30'h9, 1'b0, 26'h0, 1'b0, 32'h0, 30'h3000_1234, 1'b1, 1'b1));
        runVec("pend_jump_after", idle(30'h3000_1235, 1'b0));

        // Parked branch loses to a live jr on the accept cycle.
        runVec("pend_br_park", mk(1'b1, 1'b1, 1'b1, 30'h2, 1'b0, 26'h0, 1'b0, 32'h0, 30'h3000_1235, 1'b1, 1'b0));
        runVec("pend_br_live_jr", mk(1'b0, 1'b1, 1'b0, 30'h0, 1'b0, 26'h0, 1'b1, 32'h0000_0800, 30'h200, 1'b1, 1'b1));
        runVec("pend_br_cleared", idle(30'h201, 1'b0));

        runVec("wrap_jr", mk(1'b0, 1'b1, 1'b0, 30'h0, 1'b0, 26'h0, 1'b1, 32'hFFFF_FFFC, 30'h3FFF_FFFF, 1'b1, 1'b1));
        runVec("wrap_seq", idle(30'h0, 1'b0));
        runVec("wrap_branch", mk(1'b0, 1'b1, 1'b1, 30'h3FFF_FFFE, 1'b0, 26'h0, 1'b0, 32'h0, 30'h3FFF_FFFF, 1'b1, 1'b1));
        runVec("wrap_seq2", idle(30'h0, 1'b0));
        runVec("pre_hold", idle(30'h1, 1'b0));

        // Reset lands mid-HOLD with a jump parked; nothing of it may survive.
        runVec("hold_pending", mk(1'b1, 1'b1, 1'b0, 30'h0, 1'b1, 26'h777, 1'b0, 32'h0, 30'h1, 1'b1, 1'b0));
        #2;
        reset = 1'b1;
        #1;
        checkOutput("reset_mid_hold", 30'h0, 1'b0, 1'b0);
        @(negedge clk);
        stall = 1'b0;
        jump  = 1'b0;
        reset = 1'b0;
        #1;
        checkOutput("reboot", 30'h0, 1'b0, 1'b0);
        runVec("reboot_run", idle(30'h0, 1'b0));
        runVec("reboot_no_pending", idle(30'h1, 1'b0));

`ifdef PC_SEQUENCER_REDIRECT_CNT_EN
        applied++;
        if (redirect_cnt !== 16'h0) begin
            miscompares++;
            $display("[TB] FAIL cnt_after_reset: got %h want 0000", redirect_cnt);
        end
        applyStimulus(mk(1'b0, 1'b1, 1'b1, 30'h0, 1'b0, 26'h0, 1'b0, 32'h0, 30'h0, 1'b1, 1'b1));
        repeat (4) @(posedge clk);
        #1;
        applied++;
        if (redirect_cnt !== 16'd4) begin
            miscompares++;
            $display("[TB] FAIL cnt_small: got %h want 0004", redirect_cnt);
        end
        repeat (69995) @(posedge clk);
        #1;
        applied++;
        if (redirect_cnt !== 16'hFFFF) begin
            miscompares++;
            $display("[TB] FAIL cnt_saturate: got %h want ffff", redirect_cnt);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule
